// File: rtl/avalon_bridge_pkg.sv
// Shared types and constants for the Avalon wait-state bridge.
// The optional LFSR wait-count mode is enabled by defining WAITSTATE_LFSR_EN.
package avalon_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } bridge_state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int         WAIT_MAX  = 15;

  function automatic logic [3:0] clamp_wait(input logic [3:0] raw, input logic [3:0] limit);
    return (raw < limit) ? raw : limit;
  endfunction

endpackage

// File: rtl/avalon_waitstate_bridge_ws_lfsr.sv
// 8-bit Fibonacci LFSR supplying per-transfer wait counts; used only when
// WAITSTATE_LFSR_EN is defined.
module ws_lfsr
  import avalon_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset)
      value <= LFSR_SEED;
    else if (advance)
      value <= {value[6:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/avalon_waitstate_bridge.sv
// Avalon-MM bridge inserting programmable wait states between CPU and RAM.
// Define WAITSTATE_LFSR_EN to draw each transfer's wait count from ws_lfsr.
module avalon_waitstate_bridge
  import avalon_bridge_pkg::*;
#(
  parameter int WAIT_CYCLES = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      m_address,
  input  logic             m_read,
  input  logic             m_write,
  input  logic [31:0]      m_writedata,
  input  logic [3:0]       m_byteenable,
  output logic             m_waitrequest,
  output logic [31:0]      m_readdata,
  output logic [31:0]      s_address,
  output logic             s_read,
  output logic             s_write,
  output logic [31:0]      s_writedata,
  output logic [3:0]       s_byteenable,
  input  logic             s_waitrequest,
  input  logic [31:0]      s_readdata,
  output logic [CNT_W-1:0] txn_count,
  output logic             protocol_err
);

  localparam logic [3:0] WAIT_LIMIT = 4'((WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES);

  bridge_state_t state, next_state;
  logic [3:0]    cnt;
  logic [3:0]    wait_load;
  logic          cap_write;
  logic          accept;
  logic          write_dir;

  assign accept    = (state == IDLE) && (m_read || m_write);
  // A simultaneous read+write request resolves to a write.
  assign write_dir = accept ? m_write : cap_write;

`ifdef WAITSTATE_LFSR_EN
  logic [7:0] lfsr_value;

  ws_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
    .value   (lfsr_value)
  );

  assign wait_load = clamp_wait(lfsr_value[3:0], WAIT_LIMIT);
`else
  assign wait_load = WAIT_LIMIT;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // NOTE: next_state and m_waitrequest get defaults first so no path through
  // the case statement can infer a latch.
  always_comb begin
    next_state    = state;
    m_waitrequest = (state != DONE) || reset;
    case (state)
      IDLE:    if (m_read || m_write) next_state = (wait_load == 4'd0) ? ISSUE : WAIT;
      WAIT:    if (cnt == 4'd1) next_state = ISSUE;
      ISSUE:   if (!s_waitrequest) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= 4'd0;
      cap_write    <= 1'b0;
      s_address    <= 32'd0;
      s_writedata  <= 32'd0;
      s_byteenable <= 4'd0;
      s_read       <= 1'b0;
      s_write      <= 1'b0;
      m_readdata   <= 32'd0;
      txn_count    <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (accept) begin
        cnt          <= wait_load;
        cap_write    <= m_write;
        s_address    <= m_address;
        s_writedata  <= m_writedata;
        s_byteenable <= m_byteenable;
        if (m_read && m_write)
          protocol_err <= 1'b1;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end

      // Strobes track the ISSUE state exactly, so they drop on the edge leaving it.
      s_read  <= (next_state == ISSUE) && !write_dir;
      s_write <= (next_state == ISSUE) && write_dir;

      if ((state == ISSUE) && !s_waitrequest && !cap_write)
        m_readdata <= s_readdata;

      if (state == DONE)
        txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_avalon_waitstate_bridge.sv
// Self-checking bench for avalon_waitstate_bridge: directed table, reset and
// back-to-back corner cases, then randomized transfers against a memory model.
module tb_avalon_waitstate_bridge;

  localparam int WC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic        m_read, m_write, m_waitrequest;
  logic [3:0]  m_byteenable;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [15:0] txn_count;
  logic        protocol_err;

  avalon_waitstate_bridge #(.WAIT_CYCLES(WC), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .txn_count(txn_count), .protocol_err(protocol_err)
  );

  // Zero-wait instance with a narrow counter for the wrap test.
  logic [31:0] m1_address, m1_readdata, s1_address, s1_writedata, s1_readdata;
  logic        m1_read, m1_waitrequest, s1_read, s1_write, perr1;
  logic [3:0]  s1_byteenable, txn1_count;

  avalon_waitstate_bridge #(.WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset(reset),
    .m_address(m1_address), .m_read(m1_read), .m_write(1'b0),
    .m_writedata(32'h0), .m_byteenable(4'hF),
    .m_waitrequest(m1_waitrequest), .m_readdata(m1_readdata),
    .s_address(s1_address), .s_read(s1_read), .s_write(s1_write),
    .s_writedata(s1_writedata), .s_byteenable(s1_byteenable),
    .s_waitrequest(1'b0), .s_readdata(s1_readdata),
    .txn_count(txn1_count), .protocol_err(perr1)
  );

  assign s1_readdata = s1_address ^ 32'h5A5A0000;

  // RAM model with a programmable stall per transfer; reloads on reset.
  logic [31:0] ram [0:63];
  int          stall_len = 0;
  int          stall_cnt = 0;
  int          total_rd = 0, total_wr = 0;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;

  assign s_waitrequest = (s_read || s_write) && (stall_cnt < stall_len);
  assign s_readdata    = ram[s_address[7:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h240C0000 + 32'(i * 4);
      stall_cnt <= 0;
    end else begin
      if ((s_read || s_write) && s_waitrequest) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;
      if (s_write && !s_waitrequest)
        for (int b = 0; b < 4; b++)
          if (s_byteenable[b]) ram[s_address[7:2]][8*b +: 8] <= s_writedata[8*b +: 8];
    end
    if (s_read) total_rd <= total_rd + 1;
    if (s_write) begin
      total_wr   <= total_wr + 1;
      last_addr  <= s_address;
      last_wdata <= s_writedata;
      last_be    <= s_byteenable;
    end
  end

  // Reference memory: plain byte-merge model of what the RAM should hold.
  logic [31:0] ref_mem [0:63];

  function automatic void ref_init();
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h240C0000 + 32'(i * 4);
  endfunction

  function automatic void ref_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[addr[7:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int stall,
                      input bit scramble, output int nwait, output logic [31:0] rdata,
                      output int rd_cyc, output int wr_cyc);
    int r0, w0;
    r0 = total_rd;
    w0 = total_wr;
    stall_len = stall;
    @(negedge clk);
    m_read = rd; m_write = wr; m_address = addr; m_writedata = wdata; m_byteenable = be;
    nwait = 0;
    while (m_waitrequest && nwait < 100) begin
      nwait++;
      @(negedge clk);
      if (scramble && nwait == 1) begin
        m_address    = $urandom;
        m_writedata  = $urandom;
        m_byteenable = 4'($urandom);
        m_read       = 1'($urandom_range(0, 1));
        m_write      = 1'($urandom_range(0, 1));
      end
    end
    rdata   = m_readdata;
    m_read  = 1'b0;
    m_write = 1'b0;
    @(negedge clk);
    rd_cyc = total_rd - r0;
    wr_cyc = total_wr - w0;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    int          stall;
    int          exp_wait;
    logic [31:0] exp_rdata;
    int          exp_rd_cyc, exp_wr_cyc;
    logic        exp_perr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          nwait, rd_cyc, wr_cyc, n;
    logic [31:0] rdata, exp_rdata, addr, wdata;
    logic [3:0]  be;
    logic        rd, wr, exp_perr;
    int          exp_count, stall, kind;

    vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        4'hF, 0, 5, 32'h240C0010, 1, 0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'h3, 0, 5, 32'h240C0010, 0, 1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0,        4'hF, 0, 5, 32'h240CBEEF, 1, 0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,        4'hF, 4, 9, 32'h240C0010, 5, 0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h30, 32'h12345678, 4'hF, 1, 6, 32'h240C0010, 0, 2, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h30, 32'h0,        4'hF, 0, 5, 32'h12345678, 1, 0, 1'b1};

    reset = 1'b1;
    m_read = 1'b0; m_write = 1'b0; m_address = '0; m_writedata = '0; m_byteenable = '0;
    m1_read = 1'b0; m1_address = '0;
    ref_init();
    repeat (3) @(negedge clk);
    check("rst_waitreq_in_reset", 32'(m_waitrequest), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_waitreq", 32'(m_waitrequest), 32'd1);
    check("rst_strobes", {30'd0, s_read, s_write}, 32'd0);
    check("rst_s_address", s_address, 32'd0);
    check("rst_s_writedata", s_writedata, 32'd0);
    check("rst_s_byteenable", 32'(s_byteenable), 32'd0);
    check("rst_m_readdata", m_readdata, 32'd0);
    check("rst_txn_count", 32'(txn_count), 32'd0);
    check("rst_protocol_err", 32'(protocol_err), 32'd0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].stall,
           1'b0, nwait, rdata, rd_cyc, wr_cyc);
      check($sformatf("vec%0d_wait", i), 32'(nwait), 32'(vecs[i].exp_wait));
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_rd_cycles", i), 32'(rd_cyc), 32'(vecs[i].exp_rd_cyc));
      check($sformatf("vec%0d_wr_cycles", i), 32'(wr_cyc), 32'(vecs[i].exp_wr_cyc));
      check($sformatf("vec%0d_perr", i), 32'(protocol_err), 32'(vecs[i].exp_perr));
      check($sformatf("vec%0d_txn_count", i), 32'(txn_count), 32'(i + 1));
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_s_address", i), last_addr, vecs[i].addr);
        check($sformatf("vec%0d_s_writedata", i), last_wdata, vecs[i].wdata);
        check($sformatf("vec%0d_s_byteenable", i), 32'(last_be), 32'(vecs[i].be));
        ref_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      end
    end

    // Reset while ISSUE is stalled by the RAM.
    stall_len = 10;
    @(negedge clk);
    m_read = 1'b1; m_address = 32'h10;
    n = 0;
    while (!s_read && n < 20) begin n++; @(negedge clk); end
    check("issue_reached", 32'(s_read), 32'd1);
    reset = 1'b1; m_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ref_init();
    check("rst_issue_s_read", 32'(s_read), 32'd0);
    check("rst_issue_waitreq", 32'(m_waitrequest), 32'd1);
    check("rst_issue_txn_count", 32'(txn_count), 32'd0);
    check("rst_issue_perr", 32'(protocol_err), 32'd0);
    check("rst_issue_s_address", s_address, 32'd0);
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, nwait, rdata, rd_cyc, wr_cyc);
    check("post_rst_wait", 32'(nwait), 32'(WC + 2));
    check("post_rst_rdata", rdata, 32'h240C0010);
    check("post_rst_txn_count", 32'(txn_count), 32'd1);

    // Randomized transfers against the reference memory.
    exp_count = 1;
    exp_rdata = 32'h240C0010;
    exp_perr  = 1'b0;
    for (int t = 0; t < 40; t++) begin
      kind  = $urandom_range(0, 9);
      rd    = (kind < 5);
      wr    = (kind == 0) || (kind >= 5);
      addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      wdata = $urandom;
      be    = 4'($urandom);
      stall = $urandom_range(0, 3);
      xfer(rd, wr, addr, wdata, be, stall, 1'b1, nwait, rdata, rd_cyc, wr_cyc);
      if (wr) ref_write(addr, wdata, be);
      else exp_rdata = ref_mem[addr[7:2]];
      if (rd && wr) exp_perr = 1'b1;
      exp_count++;
      check($sformatf("rnd%0d_wait", t), 32'(nwait), 32'(WC + 2 + stall));
      check($sformatf("rnd%0d_rdata", t), rdata, exp_rdata);
      check($sformatf("rnd%0d_txn_count", t), 32'(txn_count), 32'(exp_count % 65536));
      check($sformatf("rnd%0d_perr", t), 32'(protocol_err), 32'(exp_perr));
    end

    // Zero-wait back-to-back reads, 2^4+1 of them, counter wraps to 1.
    @(negedge clk);
    m1_read = 1'b1;
    m1_address = 32'h0;
    for (int k = 0; k < 17; k++) begin
      n = 0;
      while (m1_waitrequest && n < 10) begin n++; @(negedge clk); end
      check($sformatf("b2b%0d_latency", k), 32'(n), 32'd2);
      check($sformatf("b2b%0d_rdata", k), m1_readdata, m1_address ^ 32'h5A5A0000);
      m1_address = 32'((k + 1) * 4);
      @(negedge clk);
    end
    m1_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_txn_wrap", 32'(txn1_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
